// File: rtl/tia_hsync_counter_pkg.sv
// tia_hsync_counter_pkg: shared widths, LFSR decode constants and types for the TIA horizontal timing generator
package tia_hsync_counter_pkg;

    localparam int LFSR_W = 6;

    // LFSR states for the scan-line indices that trigger decode actions.
    // Each is the value reached after that many advances from 6'b000000.
    localparam logic [LFSR_W-1:0] LFSR_IDX0  = 6'b000000;
    localparam logic [LFSR_W-1:0] LFSR_IDX4  = 6'b111100;
    localparam logic [LFSR_W-1:0] LFSR_IDX8  = 6'b110111;
    localparam logic [LFSR_W-1:0] LFSR_IDX12 = 6'b001111;
    localparam logic [LFSR_W-1:0] LFSR_IDX16 = 6'b011100;
    localparam logic [LFSR_W-1:0] LFSR_IDX18 = 6'b010111;
    localparam logic [LFSR_W-1:0] LFSR_IDX36 = 6'b101100;
    // State reached after 56 advances; the line wraps from here to index 0
    localparam logic [LFSR_W-1:0] END_STATE  = 6'b010100;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_e;

    typedef struct packed {
        logic hsync;
        logic hblank;
        logic cb;
        logic center;
        logic line_end;
    } line_sig_t;

    localparam line_sig_t SIG_RESET = '{hsync: 1'b0, hblank: 1'b1, cb: 1'b0, center: 1'b0, line_end: 1'b0};

    // One advance of the 57-state line counter, including the wrap at END_STATE
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s == END_STATE) ? '0 : {~(s[0] ^ s[1]), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/tia_lfsr6.sv
// tia_lfsr6: 6-bit polynomial line counter with END_STATE wrap and clear priority
module tia_lfsr6
    import tia_hsync_counter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              clear,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] r_state;

    // Clear beats advance so a line restart overrides a coincident step or wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= '0;
        else r_state <= clear ? '0 : advance ? lfsr_step(r_state) : r_state;
    end

    assign state = r_state;

endmodule

// File: rtl/tia_hsync_counter.sv
// tia_hsync_counter: colour-clock /4 phase enables, 57-state line counter and registered line-timing decode
module tia_hsync_counter
    import tia_hsync_counter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rsync,
    input  logic              hmove,
    output logic              phi1_en,
    output logic              phi2_en,
    output logic [LFSR_W-1:0] lfsr,
    output logic              hsync,
    output logic              hblank,
    output logic              cb,
    output logic              center,
    output logic              line_end
);

    phase_e            r_phase;
    phase_e            w_phase_nx;
    line_sig_t         r_sig;
    line_sig_t         w_sig_nx;
    logic              r_late_hb;
    logic              w_late_hb_nx;
    logic              w_adv;
    logic              w_step;
    logic [LFSR_W-1:0] w_lfsr;
    logic [LFSR_W-1:0] w_next;
    logic              w_e0;
    logic              w_e4;
    logic              w_e8;
    logic              w_e12;
    logic              w_e16;
    logic              w_e18;
    logic              w_e36;

    tia_lfsr6 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (w_adv),
        .clear   (rsync),
        .state   (w_lfsr)
    );

    // Decode looks at the state being entered, so actions land on the same edge as the advance
    assign w_adv  = (r_phase == PH2);
    assign w_step = w_adv & ~rsync;
    assign w_next = lfsr_step(w_lfsr);
    assign w_e0   = rsync | (w_adv & (w_next == LFSR_IDX0));
    assign w_e4   = w_step & (w_next == LFSR_IDX4);
    assign w_e8   = w_step & (w_next == LFSR_IDX8);
    assign w_e12  = w_step & (w_next == LFSR_IDX12);
    assign w_e16  = w_step & (w_next == LFSR_IDX16);
    assign w_e18  = w_step & (w_next == LFSR_IDX18);
    assign w_e36  = w_step & (w_next == LFSR_IDX36);

    // Phase sequence 0,1,2,3; rsync parks it at 3 so the next advance is four clocks away
    always_comb begin
        w_phase_nx = rsync ? PH3 : phase_e'(r_phase + 2'd1);
    end

    // Phase register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_phase <= PH3;
        else r_phase <= w_phase_nx;
    end

    // Late-blank request: hmove sets, entry to 18 clears, a coincident set wins
    always_comb begin
        w_late_hb_nx = hmove | (r_late_hb & ~w_e18);
    end

    // Late-blank register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_late_hb <= 1'b0;
        else r_late_hb <= w_late_hb_nx;
    end

    // Next values of the line-timing outputs; the pulses last one clock
    always_comb begin
        w_sig_nx          = r_sig;
        w_sig_nx.center   = w_e36;
        w_sig_nx.line_end = w_e0;
        w_sig_nx.hsync    = w_e0 | w_e8 ? 1'b0 : w_e4 ? 1'b1 : r_sig.hsync;
        w_sig_nx.cb       = w_e0 | w_e12 ? 1'b0 : w_e8 ? 1'b1 : r_sig.cb;
        w_sig_nx.hblank   = w_e0 ? 1'b1 :
                            w_e18 | (w_e16 & ~(r_late_hb | hmove)) ? 1'b0 : r_sig.hblank;
    end

    // Line-timing output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sig <= SIG_RESET;
        else r_sig <= w_sig_nx;
    end

    assign phi1_en  = (r_phase == PH0);
    assign phi2_en  = (r_phase == PH2);
    assign lfsr     = w_lfsr;
    assign hsync    = r_sig.hsync;
    assign hblank   = r_sig.hblank;
    assign cb       = r_sig.cb;
    assign center   = r_sig.center;
    assign line_end = r_sig.line_end;

endmodule
